// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encoding and parity-type constants,
// common to the transmitter and the future receiver.
package uart_defs;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE   = 3'd0;
    localparam uart_state_t ST_START  = 3'd1;
    localparam uart_state_t ST_DATA   = 3'd2;
    localparam uart_state_t ST_PARITY = 3'd3;
    localparam uart_state_t ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // data_xor is the XOR reduction of the payload; odd parity inverts it.
    function automatic logic parity_bit(input logic data_xor, input logic par_typ);
        return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload latch plus LSB-first shifter. o_bit is the next bit to put on the line;
// o_done flags that the bit currently on the line is the last payload bit.
module uart_tx_serializer #(
    parameter int DATA_WD = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_shift,
    input  logic [DATA_WD-1:0] i_data,
    output logic               o_bit,
    output logic               o_done,
    output logic [DATA_WD-1:0] o_data
);

    localparam int              CNT_WD   = (DATA_WD > 1) ? $clog2(DATA_WD) : 1;
    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(DATA_WD - 1);

    logic [DATA_WD-1:0] data_q;
    logic [DATA_WD-1:0] shreg_q;
    logic [CNT_WD-1:0]  cnt_q;
    logic               first_q;

    // The first shift moves bit 0 onto the line, so it does not advance the index.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            data_q  <= '0;
            shreg_q <= '0;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else if (i_load) begin
            data_q  <= i_data;
            shreg_q <= i_data;
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else if (i_shift) begin
            shreg_q <= shreg_q >> 1;
            first_q <= 1'b0;
            if (!first_q) begin
                cnt_q <= cnt_q + CNT_WD'(1);
            end
        end
    end

    always_comb begin
        o_bit  = shreg_q[0];
        o_done = (cnt_q == CNT_LAST);
        o_data = data_q;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one bit per rising edge of the bit clock; start, payload LSB first,
// optional parity, stop. Line and busy outputs are registered from the next state.
module uart_tx
    import uart_defs::*;
#(
    parameter int DATA_WD = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [DATA_WD-1:0] i_data,
    input  logic               i_data_valid,
    input  logic               i_par_en,
    input  logic               i_par_typ,
    output logic               o_tx_out,
    output logic               o_busy
);

    uart_state_t        state_q;
    uart_state_t        state_d;
    logic               par_en_q;
    logic               par_typ_q;
    logic               load;
    logic               shift;
    logic               ser_bit;
    logic               ser_done;
    logic [DATA_WD-1:0] ser_data;
    logic               par_bit;
    logic               tx_d;
    logic               busy_d;

    uart_tx_serializer #(
        .DATA_WD (DATA_WD)
    ) u_serializer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (load),
        .i_shift (shift),
        .i_data  (i_data),
        .o_bit   (ser_bit),
        .o_done  (ser_done),
        .o_data  (ser_data)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_data_valid) begin
                    state_d = ST_START;
                    load    = 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_DATA;
                shift   = 1'b1;
            end
            ST_DATA: begin
                if (ser_done) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP;
                end else begin
                    shift = 1'b1;
                end
            end
            ST_PARITY: state_d = ST_STOP;
            ST_STOP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        par_bit = parity_bit(^ser_data, par_typ_q);
        // Decode on the next state so the line changes on the same edge as the FSM.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = ser_bit;
            ST_PARITY: tx_d = par_bit;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= ST_IDLE;
            par_en_q  <= 1'b0;
            par_typ_q <= PAR_EVEN;
            o_tx_out  <= 1'b1;
            o_busy    <= 1'b0;
        end else begin
            state_q  <= state_d;
            o_tx_out <= tx_d;
            o_busy   <= busy_d;
            if (load) begin
                par_en_q  <= i_par_en;
                par_typ_q <= i_par_typ;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: 8-bit and 5-bit instances against a frame-queue model,
// plus directed frames with hand-computed line sequences.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d8 = '0;
    logic       v8 = 1'b0, pe8 = 1'b0, pt8 = 1'b0;
    logic       tx8, busy8;
    logic [4:0] d5 = '0;
    logic       v5 = 1'b0, pe5 = 1'b0, pt5 = 1'b0;
    logic       tx5, busy5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx #(.DATA_WD(8)) dut8 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (d8),
        .i_data_valid (v8),
        .i_par_en     (pe8),
        .i_par_typ    (pt8),
        .o_tx_out     (tx8),
        .o_busy       (busy8)
    );

    uart_tx #(.DATA_WD(5)) dut5 (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_data       (d5),
        .i_data_valid (v5),
        .i_par_en     (pe5),
        .i_par_typ    (pt5),
        .o_tx_out     (tx5),
        .o_busy       (busy5)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame as line bits, bit i = cycle i after the accept edge.
    function automatic logic [15:0] frame_bits(input logic [7:0] d, input int wd,
                                               input logic pe, input logic pt);
        logic [15:0] f;
        logic [7:0]  m;
        int          ones;
        m    = d & 8'((1 << wd) - 1);
        ones = $countones(m);
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < wd; i++) f[1 + i] = m[i];
        if (pe) f[wd + 1] = 1'((ones % 2) == 1) ^ pt;
        return f;
    endfunction

    // Model: accept only when the line was idle in the cycle before the edge.
    bit          q8[$];
    bit          q5[$];
    logic        e8_tx = 1'b1, e8_busy = 1'b0;
    logic        e5_tx = 1'b1, e5_busy = 1'b0;
    logic [15:0] f8, f5;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q8.delete();
            e8_tx   <= 1'b1;
            e8_busy <= 1'b0;
        end else begin
            if (!e8_busy && v8) begin
                f8 = frame_bits(d8, 8, pe8, pt8);
                for (int i = 0; i < 10 + int'(pe8); i++) q8.push_back(f8[i]);
            end
            if (q8.size() > 0) begin
                e8_tx   <= q8.pop_front();
                e8_busy <= 1'b1;
            end else begin
                e8_tx   <= 1'b1;
                e8_busy <= 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q5.delete();
            e5_tx   <= 1'b1;
            e5_busy <= 1'b0;
        end else begin
            if (!e5_busy && v5) begin
                f5 = frame_bits(8'(d5), 5, pe5, pt5);
                for (int i = 0; i < 7 + int'(pe5); i++) q5.push_back(f5[i]);
            end
            if (q5.size() > 0) begin
                e5_tx   <= q5.pop_front();
                e5_busy <= 1'b1;
            end else begin
                e5_tx   <= 1'b1;
                e5_busy <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("tx8_model", 32'(tx8), 32'(e8_tx));
        check("busy8_model", 32'(busy8), 32'(e8_busy));
        check("tx5_model", 32'(tx5), 32'(e5_tx));
        check("busy5_model", 32'(busy5), 32'(e5_busy));
    end

    // Drives one frame request, with a stray valid pulse mid-frame; optionally
    // disturbs the inputs after accept. Samples n+2 cycles from the start bit.
    task automatic run_frame(input logic sel5, input logic [7:0] d, input logic pe,
                             input logic pt, input int n, input logic chg,
                             output logic [31:0] seq, output int busy_n);
        seq    = '0;
        busy_n = 0;
        if (sel5) begin
            d5 = d[4:0]; pe5 = pe; pt5 = pt; v5 = 1'b1;
        end else begin
            d8 = d; pe8 = pe; pt8 = pt; v8 = 1'b1;
        end
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i < n) seq = {seq[30:0], (sel5 ? tx5 : tx8)};
            busy_n += int'(sel5 ? busy5 : busy8);
            if (i == 0 || i == 5) begin
                v8 = 1'b0;
                v5 = 1'b0;
            end
            if (i == 4) begin
                if (sel5) v5 = 1'b1; else v8 = 1'b1;
            end
            if (chg && i == 2) begin
                d8 = 8'hFF; d5 = 5'h1F;
                pe8 = ~pe8; pt8 = ~pt8; pe5 = ~pe5; pt5 = ~pt5;
            end
        end
    endtask

    logic [31:0] seq, bseq;
    int          bn, bad;

    initial begin
        #1 rst = 1'b0;
        #1;
        check("rst_tx8", 32'(tx8), 32'd1);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_tx5", 32'(tx5), 32'd1);
        check("rst_busy5", 32'(busy5), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Valid present with release: accepted on the first edge out of reset.
        run_frame(1'b0, 8'hA5, 1'b0, 1'b0, 10, 1'b0, seq, bn);
        check("a5_noparity_seq", seq, 32'b0101001011);
        check("a5_noparity_busy", 32'(bn), 32'd10);

        run_frame(1'b0, 8'hA5, 1'b1, 1'b0, 11, 1'b0, seq, bn);
        check("a5_even_seq", seq, 32'b01010010101);
        check("a5_even_busy", 32'(bn), 32'd11);

        run_frame(1'b0, 8'hA5, 1'b1, 1'b1, 11, 1'b0, seq, bn);
        check("a5_odd_seq", seq, 32'b01010010111);

        run_frame(1'b0, 8'h01, 1'b1, 1'b0, 11, 1'b1, seq, bn);
        check("01_even_chg_seq", seq, 32'b01000000011);
        check("01_even_chg_busy", 32'(bn), 32'd11);

        run_frame(1'b1, 8'h13, 1'b1, 1'b1, 8, 1'b0, seq, bn);
        check("w5_13_odd_seq", seq, 32'b01100101);
        check("w5_13_odd_busy", 32'(bn), 32'd8);

        // Valid held high: frames back to back with one idle cycle between.
        d8 = 8'h3C; pe8 = 1'b0; pt8 = 1'b0; v8 = 1'b1;
        seq = '0;
        bseq = '0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            seq  = {seq[30:0], tx8};
            bseq = {bseq[30:0], busy8};
        end
        v8 = 1'b0;
        check("b2b_seq", seq, 32'b000111100110001111001);
        check("b2b_busy", bseq, 32'b111111111101111111111);
        repeat (3) @(negedge clk);

        // Reset while payload bit 4 of 8'hA5 (a zero) is on the line.
        d8 = 8'hA5; pe8 = 1'b0; v8 = 1'b1;
        @(negedge clk);
        v8 = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_tx_bit4", 32'(tx8), 32'd0);
        check("mid_busy", 32'(busy8), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_tx", 32'(tx8), 32'd1);
        check("abort_busy", 32'(busy8), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        repeat (12) begin
            @(negedge clk);
            bad += int'(!tx8) + int'(busy8);
        end
        check("post_abort_idle", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
